// File: rtl/pwm_tx_pkg.sv
// Shared types and constants for the PWM excitation transmitter.
//   pwm_tx_state_t         : modulator state (idle, on phase, off phase)
//   PWM_TX_MIN_HALF_PERIOD : smallest phase length accepted; smaller requests are raised to it
package pwm_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } pwm_tx_state_t;

  localparam int unsigned PWM_TX_MIN_HALF_PERIOD = 2;

endpackage

// File: rtl/pwm_excitation_tx_if.sv
// Control/status bundle between the excitation controller and pwm_excitation_tx.
//   master : drives enable and half_period, observes the modulator outputs
//   slave  : the modulator itself
// Signals: enable, half_period[HP_W], switch_pwm, phase_on, sample_valid,
//          period_start, cycle_count[HP_W], busy
interface pwm_excitation_tx_if #(
  parameter int unsigned HP_W = 16
);

  logic            enable;
  logic [HP_W-1:0] half_period;
  logic            switch_pwm;
  logic            phase_on;
  logic            sample_valid;
  logic            period_start;
  logic [HP_W-1:0] cycle_count;
  logic            busy;

  modport master (
    output enable,
    output half_period,
    input  switch_pwm,
    input  phase_on,
    input  sample_valid,
    input  period_start,
    input  cycle_count,
    input  busy
  );

  modport slave (
    input  enable,
    input  half_period,
    output switch_pwm,
    output phase_on,
    output sample_valid,
    output period_start,
    output cycle_count,
    output busy
  );

endinterface

// File: rtl/pwm_excitation_tx_phase_timer.sv
// phase_timer: loadable down-counter that times one PWM phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_val (and restart the blank window) on this edge
//   load_val    : phase length minus one
//   tc          : counter is at zero (last cycle of the phase)
//   blank_next  : the cycle after this edge lies inside the blank window
// With PWM_TX_BLANKING_EN defined a second counter tracks the first BLANK_CYCLES
// cycles of each phase; otherwise blank_next is tied low and no counter exists.
module phase_timer #(
  parameter int unsigned W            = 16,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         blank_next
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc = (cnt_q == '0);

`ifdef PWM_TX_BLANKING_EN
  localparam int unsigned BW        = $clog2(BLANK_CYCLES + 2);
  localparam logic [BW-1:0] BlankInit = BW'(BLANK_CYCLES);

  // Remaining blank cycles including the current one; saturates at zero.
  logic [BW-1:0] blank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (load) begin
      blank_q <= BlankInit;
    end else if (blank_q != '0) begin
      blank_q <= blank_q - BW'(1);
    end
  end

  assign blank_next = load ? (BlankInit != '0) : (blank_q > BW'(1));
`else
  assign blank_next = 1'b0;
`endif

endmodule

// File: rtl/pwm_excitation_tx.sv
// pwm_excitation_tx: switching PWM for the lock-in excitation source.
// Each on and off phase lasts exactly hp_lat cycles; hp_lat is max(half_period, 2)
// captured at every on-phase entry. A stop request is honoured only at the end of
// an off phase, so periods are never truncated.
//   clk, rst_n : 100 MHz clock, asynchronous active-low reset
//   bus        : pwm_excitation_tx_if slave (enable, half_period in; switch_pwm,
//                phase_on, sample_valid, period_start, cycle_count, busy out)
// Optional: PWM_TX_BLANKING_EN gates sample_valid low for the first BLANK_CYCLES
// cycles of each phase; without it sample_valid equals busy.
module pwm_excitation_tx
  import pwm_tx_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned HP_W         = 16
) (
  input logic                clk,
  input logic                rst_n,
  pwm_excitation_tx_if.slave bus
);

  localparam logic [HP_W-1:0] MinHp = HP_W'(PWM_TX_MIN_HALF_PERIOD);

  pwm_tx_state_t   state_q, state_d;
  logic [HP_W-1:0] hp_lat_q, hp_lat_d;
  logic [HP_W-1:0] hp_clamped;
  logic [HP_W-1:0] load_val;
  logic [HP_W-1:0] cycle_count_q, cycle_count_d;
  logic            load, tc, blank_next;
  logic            period_start_d;
  logic            switch_pwm_q, phase_on_q, sample_valid_q, period_start_q, busy_q;

  assign hp_clamped = (bus.half_period < MinHp) ? MinHp : bus.half_period;

  phase_timer #(
    .W            (HP_W),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .tc         (tc),
    .blank_next (blank_next)
  );

  always_comb begin
    state_d        = state_q;
    hp_lat_d       = hp_lat_q;
    load           = 1'b0;
    load_val       = hp_lat_q - HP_W'(1);
    cycle_count_d  = cycle_count_q;
    period_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d        = StOn;
          hp_lat_d       = hp_clamped;
          load           = 1'b1;
          load_val       = hp_clamped - HP_W'(1);
          period_start_d = 1'b1;
        end
      end
      StOn: begin
        if (tc) begin
          state_d = StOff;
          load    = 1'b1;
        end
      end
      StOff: begin
        if (tc) begin
          cycle_count_d = cycle_count_q + HP_W'(1);
          if (bus.enable) begin
            state_d        = StOn;
            hp_lat_d       = hp_clamped;
            load           = 1'b1;
            load_val       = hp_clamped - HP_W'(1);
            period_start_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the phase
  // that starts on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      hp_lat_q       <= '0;
      cycle_count_q  <= '0;
      switch_pwm_q   <= 1'b0;
      phase_on_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hp_lat_q       <= hp_lat_d;
      cycle_count_q  <= cycle_count_d;
      switch_pwm_q   <= (state_d == StOn);
      // Separate flop so the receiver's phase tag has its own driver.
      phase_on_q     <= (state_d == StOn);
      sample_valid_q <= (state_d != StIdle) && !blank_next;
      period_start_q <= period_start_d;
      busy_q         <= (state_d != StIdle);
    end
  end

  assign bus.switch_pwm   = switch_pwm_q;
  assign bus.phase_on     = phase_on_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.period_start = period_start_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pwm_excitation_tx.sv
// Bench for pwm_excitation_tx: two instances (HP_W=16/BLANK_CYCLES=3 and
// HP_W=4/BLANK_CYCLES=5) checked every cycle against a period-position model,
// plus directed scenarios with hand-computed waveforms.
module tb_pwm_excitation_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pwm_excitation_tx_if #(.HP_W(16)) bus_a ();
  pwm_excitation_tx_if #(.HP_W(4))  bus_b ();

  pwm_excitation_tx #(.BLANK_CYCLES(3), .HP_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pwm_excitation_tx #(.BLANK_CYCLES(5), .HP_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Model: whether a period is running, position within the 2*hp period,
  // the latched half period and completed-period count.
  typedef struct {
    bit          run;
    int unsigned pos;
    int unsigned hp;
    int unsigned cnt;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_step(mdl_t m, bit en, int unsigned hp_in, int unsigned w);
    mdl_t n = m;
    if (m.run && (m.pos + 1 < 2 * m.hp)) begin
      n.pos = m.pos + 1;
    end else begin
      if (m.run) n.cnt = (m.cnt + 1) & ((1 << w) - 1);
      n.run = en;
      n.pos = 0;
      if (en) n.hp = (hp_in < 2) ? 2 : hp_in;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{run: 1'b0, pos: 0, hp: 0, cnt: 0};
      mb <= '{run: 1'b0, pos: 0, hp: 0, cnt: 0};
    end else begin
      ma <= mdl_step(ma, bus_a.enable, int'(bus_a.half_period), 16);
      mb <= mdl_step(mb, bus_b.enable, int'(bus_b.half_period), 4);
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input int unsigned blank,
                     input logic sw, input logic pon, input logic sv, input logic ps,
                     input logic busy, input int unsigned cnt);
    logic [4:0] e, a;
    bit         e_sv;
    e_sv = 1'b0;
    if (m.run) begin
`ifdef PWM_TX_BLANKING_EN
      e_sv = ((m.pos % m.hp) >= blank);
`else
      e_sv = 1'b1;
`endif
    end
    e = {m.run && (m.pos < m.hp), m.run && (m.pos < m.hp), e_sv, m.run && (m.pos == 0), m.run};
    a = {sw, pon, sv, ps, busy};
    checks++;
    if ((a !== e) || (cnt != m.cnt)) begin
      errors++;
      $display("FAIL %s_cycle t=%0t: {sw,pon,sv,ps,busy}=%b cnt=%0d expected %b cnt=%0d",
               tag, $time, a, cnt, e, m.cnt);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("a", ma, 3, bus_a.switch_pwm, bus_a.phase_on, bus_a.sample_valid,
          bus_a.period_start, bus_a.busy, int'(bus_a.cycle_count));
      cmp("b", mb, 5, bus_b.switch_pwm, bus_b.phase_on, bus_b.sample_valid,
          bus_b.period_start, bus_b.busy, int'(bus_b.cycle_count));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus_a.busy || bus_b.busy) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(bus_a.busy || bus_b.busy), 0);
  endtask

  logic [31:0] swv, psv, bv, svv;

  initial begin
    bus_a.enable      = 1'b1;
    bus_a.half_period = 16'd4;
    bus_b.enable      = 1'b0;
    bus_b.half_period = 4'd0;

    // Reset held with enable high: everything stays at zero.
    repeat (3) @(negedge clk);
    chk("rst_sw", int'(bus_a.switch_pwm), 0);
    chk("rst_ps", int'(bus_a.period_start), 0);
    chk("rst_busy", int'(bus_a.busy), 0);
    chk("rst_cnt", int'(bus_a.cycle_count), 0);
    rst_n = 1'b1;

    // hp=4 after release: 4 on, 4 off, period_start every 8 cycles.
    swv = '0; psv = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      swv[i] = bus_a.switch_pwm;
      psv[i] = bus_a.period_start;
    end
    chk("t1_sw_pattern", swv[15:0], 32'h0F0F);
    chk("t1_ps_pattern", psv[15:0], 32'h0101);
    bus_a.enable = 1'b0;
    wait_idle();
    chk("t1_count", int'(bus_a.cycle_count), 2);

    // Graceful stop: enable dropped on the second on cycle, full 5+5 period runs.
    bus_a.half_period = 16'd5;
    bus_a.enable      = 1'b1;
    swv = '0; bv = '0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      swv[i] = bus_a.switch_pwm;
      bv[i]  = bus_a.busy;
      if (i == 1) chk("t2_count_start", int'(bus_a.cycle_count), 2);
      if (i == 2) bus_a.enable = 1'b0;
    end
    chk("t2_sw_pattern", swv, 32'h3E);
    chk("t2_busy_pattern", bv, 32'h7FE);
    chk("t2_count_end", int'(bus_a.cycle_count), 3);

    // Reconfiguration during on phase: 4+4 then 6+6.
    bus_a.half_period = 16'd4;
    bus_a.enable      = 1'b1;
    swv = '0; psv = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      swv[i] = bus_a.switch_pwm;
      psv[i] = bus_a.period_start;
      if (i == 2) bus_a.half_period = 16'd6;
    end
    chk("t3_sw_pattern", swv, 32'h01E0_7E1E);
    chk("t3_ps_pattern", psv, 32'h0020_0202);
    bus_a.enable = 1'b0;
    wait_idle();

    // Clamping: half_period 0 then 1 both give 2+2.
    bus_a.half_period = 16'd0;
    bus_a.enable      = 1'b1;
    swv = '0; psv = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      swv[i] = bus_a.switch_pwm;
      psv[i] = bus_a.period_start;
      if (i == 2) bus_a.half_period = 16'd1;
      if (i == 8) bus_a.enable = 1'b0;
    end
    chk("t4_sw_pattern", swv, 32'h66);
    chk("t4_ps_pattern", psv, 32'h22);
    wait_idle();

    // Blanking, hp=5: BLANK_CYCLES=3 on A, 5 on B.
    bus_a.half_period = 16'd5;
    bus_a.enable      = 1'b1;
    svv = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      svv[i] = bus_a.sample_valid;
      if (i == 1) bus_a.enable = 1'b0;
    end
`ifdef PWM_TX_BLANKING_EN
    chk("t5_sv_blank3", svv, 32'h630);
`else
    chk("t5_sv_noblank", svv, 32'h7FE);
`endif
    wait_idle();
    bus_b.half_period = 4'd5;
    bus_b.enable      = 1'b1;
    svv = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      svv[i] = bus_b.sample_valid;
      if (i == 1) bus_b.enable = 1'b0;
    end
`ifdef PWM_TX_BLANKING_EN
    chk("t5_sv_blank5", svv, 32'h0);
`else
    chk("t5_sv_noblank_b", svv, 32'h7FE);
`endif
    wait_idle();
    chk("t5_count_b", int'(bus_b.cycle_count), 1);

    // Wrap on the 4-bit counter, then asynchronous reset mid-off.
    bus_b.half_period = 4'd2;
    bus_b.enable      = 1'b1;
    for (int i = 1; i <= 67; i++) begin
      @(negedge clk);
      if (i == 57) chk("t6_count_15", int'(bus_b.cycle_count), 15);
      if (i == 61) chk("t6_count_wrap", int'(bus_b.cycle_count), 0);
    end
    chk("t6_pre_abort_busy", int'(bus_b.busy), 1);
    chk("t6_pre_abort_cnt", int'(bus_b.cycle_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_abort_sw", int'(bus_b.switch_pwm), 0);
    chk("t6_abort_busy", int'(bus_b.busy), 0);
    chk("t6_abort_cnt", int'(bus_b.cycle_count), 0);
    bus_b.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_after_busy", int'(bus_b.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_excitation_tx.md
# pwm_excitation_tx

Transmit-side modulator for the lock-in demodulation path. It generates the switching PWM that chops the excitation source, with exactly `half_period` clock cycles in each of the on and off phases. Alongside the PWM it emits phase, period-start and sample-window qualifiers, so the ADC-side receiver can pair on/off samples without edge transients. It sits between the board-level excitation driver pin and the ADC demodulation logic, all in the 100 MHz system clock domain.

## Interface
- `BLANK_CYCLES`, 100: cycles after each phase edge during which samples are invalid.
- `HP_W`, 16: width of `half_period` and `cycle_count`.
- `clk` in 1: 100 MHz system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: level; high requests modulation, low requests a clean stop.
- `half_period` in HP_W: phase length in cycles; latched only at each on-phase entry.
- `switch_pwm` out 1: excitation drive; 1 means the source is on.
- `phase_on` out 1: registered copy of `switch_pwm`, used as the receiver phase tag.
- `sample_valid` out 1: high when the current cycle is outside the blanking window of an active phase.
- `period_start` out 1: one-cycle pulse on the first cycle of each on phase.
- `cycle_count` out HP_W: count of completed on+off periods; wraps.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, ON and OFF. All outputs are registered and driven from the state and counters.
- In IDLE, `enable`=1 moves the state to ON. On that transition `hp_lat` is loaded with max(`half_period`, 2) and the phase counter is loaded with `hp_lat`-1.
- ON: the counter decrements each cycle. When it reaches 0 the state moves to OFF and the counter reloads with `hp_lat`-1.
- OFF: the counter decrements in the same way. When it reaches 0:
  - `cycle_count` increments, wrapping from 2^HP_W-1 to 0.
  - If `enable`=1, the state moves to ON, `hp_lat` is re-latched and `period_start` pulses.
  - Otherwise the state moves to IDLE.
- `enable` is sampled only on the last OFF cycle and in IDLE. A deassert mid-period always completes the current ON and OFF phases, so periods are never truncated. A deassert that is followed by a re-assert before the last OFF cycle has no effect.
- A change to `half_period` mid-period takes effect only at the next on-phase entry.
- `half_period` values of 0 and 1 are clamped to 2.
- Reset asserted in any state forces IDLE immediately and clears every output and counter. The current period is abandoned.

## Timing
- Reset values: `switch_pwm`=0, `phase_on`=0, `sample_valid`=0, `period_start`=0, `cycle_count`=0, `busy`=0.
- Latency from the `enable` rise in IDLE to `switch_pwm`=1 and `period_start`=1 is one cycle.
- Each phase lasts exactly `hp_lat` cycles, so the full period is 2·`hp_lat`.
- `cycle_count` updates on the cycle after the last OFF cycle, coincident with the next `period_start`.
- After a stop, `busy` falls on the same cycle that `switch_pwm` would have risen.

## Configuration
- With `PWM_TX_BLANKING_EN` defined:
  - `sample_valid` is 0 for the first `BLANK_CYCLES` cycles of each phase and 1 for the remainder.
  - If `BLANK_CYCLES` ≥ `hp_lat`, `sample_valid` stays 0 for the whole phase.
- Without the macro, `sample_valid` = `busy`, and no blanking counter is synthesised.

## Structure
- Package `pwm_tx_pkg` holds:
  - the state enum `pwm_tx_state_t` (IDLE, ON, OFF);
  - the constant `PWM_TX_MIN_HALF_PERIOD` = 2.
- One sub-module, `phase_timer`: a loadable down-counter with a terminal-count output and an optional blank-window flag. It is instantiated once.

## Test plan
- Reset behaviour: `rst_n` low, then `enable`=1 with `half_period`=4 → all outputs stay 0 while reset is held. After release, `switch_pwm`=1 for 4 cycles, then 0 for 4 cycles, repeating, with `period_start` pulsing every 8 cycles.
- Graceful stop: `half_period`=5, `enable` dropped on cycle 2 of ON → ON completes (5 cycles) and OFF completes (5 cycles). Then IDLE, `busy`=0, and `cycle_count` increases by exactly 1.
- Mid-period reconfiguration: `half_period` changed from 4 to 6 during ON → the current period stays 4+4. The next period is 6+6.
- Clamping: `half_period`=0, then 1 → each is treated as 2, giving a 4-cycle period.
- Blanking, with `PWM_TX_BLANKING_EN`, `BLANK_CYCLES`=3, `half_period`=5 → in every phase, `sample_valid` is 0 for 3 cycles then 1 for 2. With `BLANK_CYCLES`=5, `sample_valid` is always 0.
- Wrap and reset abort: `HP_W`=4, run 16 periods → `cycle_count` goes 15→0. Reset asserted mid-OFF → `switch_pwm`, `busy` and `cycle_count` are 0 asynchronously.
